// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Initiator side of the instruction-memory read interface. Holds the PC,
//   drives it as the word address into a combinational-read instruction
//   memory, captures each returned word together with its PC into a small
//   prefetch FIFO, and presents the FIFO head to decode with a valid/ready
//   handshake. A redirect from execute flushes all wrong-path words and
//   restarts fetch at the redirect target.
//
// Configuration:
//   FETCH_JUMP_PREDECODE_EN  when defined, a pushed JUMP word (opcode 6'b010101)
//                            steers the next PC to its 26-bit target instead
//                            of PC+1. The JUMP word itself is still delivered.
//
// Parameters:
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//   MEM_WORDS   number of valid instruction words; PCs at or above it are not fetched
//   RESET_PC    PC loaded on reset
//
// Ports:
//   clock            in   single clock, all state updates on posedge
//   resetn           in   asynchronous active-low reset
//   imem_address     out  word address to instruction memory (= pc)
//   imem_dataout     in   instruction word for imem_address, same cycle
//   inst_valid       out  FIFO head holds a valid instruction
//   inst_ready       in   decode accepts the head this cycle
//   inst             out  head instruction word
//   inst_pc          out  word address the head instruction came from
//   redirect_valid   in   execute resolved a taken branch/jump
//   redirect_target  in   new word address
//   fetch_oob        out  pc >= MEM_WORDS; fetching halted until redirect/reset
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MEM_WORDS  = 25,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clock,
   input  logic        resetn,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_dataout,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        fetch_oob
);

   localparam int unsigned     PTR_W       = $clog2(FIFO_DEPTH);
   localparam int unsigned     CNT_W       = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]     MEM_WORDS_C = 32'(MEM_WORDS);

   // Control state
   logic [31:0]      pc_q,      pc_d;
   logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
   logic [CNT_W-1:0] count_q,   count_d;

   // Registered head copy; holds its last value while the FIFO is empty
   logic [31:0]      inst_q,    inst_d;
   logic [31:0]      inst_pc_q, inst_pc_d;

   // Prefetch storage (data only, never reset)
   logic [31:0]      fifo_inst_q [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

   logic             push;
   logic             pop;
   logic [CNT_W-1:0] remain;
   logic [31:0]      next_fetch_pc;

   assign imem_address = pc_q;
   assign fetch_oob    = (pc_q >= MEM_WORDS_C);
   assign inst_valid   = (count_q != '0);
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;

   // A redirect flushes the FIFO, so a concurrent pop is not credited.
   assign pop  = inst_valid & inst_ready & ~redirect_valid;
   // A full FIFO still accepts a push when its head leaves in the same cycle.
   assign push = ~redirect_valid & ~fetch_oob & ((count_q < DEPTH_C) | pop);

   // Entries left after this cycle's pop, before counting the push
   assign remain = count_q - CNT_W'(pop);

`ifdef FETCH_JUMP_PREDECODE_EN
   assign next_fetch_pc = (imem_dataout[31:26] == 6'b010101)
                          ? {6'b0, imem_dataout[25:0]}
                          : pc_q + 32'd1;
`else
   assign next_fetch_pc = pc_q + 32'd1;
`endif

   always_comb begin
      pc_d      = pc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;

      if (redirect_valid) begin
         pc_d     = redirect_target;
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = next_fetch_pc;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = remain + CNT_W'(push);

         // Next head: the word being pushed if nothing older remains,
         // otherwise the stored entry at the new read pointer.
         if (remain == '0) begin
            if (push) begin
               inst_d    = imem_dataout;
               inst_pc_d = pc_q;
            end
         end else begin
            inst_d    = fifo_inst_q[rd_ptr_d];
            inst_pc_d = fifo_pc_q[rd_ptr_d];
         end
      end
   end

   // ---- fetch -> prefetch FIFO boundary ----
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_q      <= RESET_PC;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= imem_dataout;
         fifo_pc_q[wr_ptr_q]   <= pc_q;
      end
   end

endmodule
